seg7_scan: RTL and testbench

- Drives a 4-digit common-anode 7-segment display from the BCD clock digits (hour1, hour0, min1, min0) produced by the timekeeping counter.
- Sits directly downstream of the timer and directly feeds the board pins.
- Time-multiplexes one digit at a time and snapshots the inputs once per scan frame, so a digit rollover never tears the display.
- Drives the hour/minute colon via the decimal point of the hour0 digit.

---
 rtl/seg7_scan.sv | 159 +++++++++++++++
 tb/tb_seg7_scan.sv | 124 ++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Scans four BCD clock digits onto a common-anode 7-segment display, with the colon on hour0's dp.
// One cycle of output latency; inputs are sampled only at frame wrap. COLON_BLINK_EN makes the colon blink.
module seg7_scan #(
  parameter int SCAN_DIV = 12500
`ifdef COLON_BLINK_EN
  , parameter int BLINK_HALF = 25000000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hour1,
  input  logic [3:0] hour0,
  input  logic [2:0] min1,
  input  logic [3:0] min0,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  typedef struct packed {
    logic [1:0] hour1;
    logic [3:0] hour0;
    logic [2:0] min1;
    logic [3:0] min0;
  } digits_t;

  localparam int                DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [6:0]        SEG_DASH = 7'b0111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    s = SEG_DASH;
    case (v)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       idx_q, idx_d;
  digits_t          shadow_q, shadow_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             tick;
  logic [3:0]       cur_val;
  logic             cur_ok;
  logic             colon_lit;

  // Slot divider, digit index and frame-wrap snapshot
  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    shadow_d  = shadow_q;
    if (tick && (idx_q == 2'd3)) begin
      shadow_d = {hour1, hour0, min1, min0};
    end
  end

  // Per-position legality differs because the tens digits have narrower ranges
  always_comb begin
    cur_val = 4'd0;
    cur_ok  = 1'b1;
    unique case (idx_q)
      2'd0: begin
        cur_val = shadow_q.min0;
        cur_ok  = (shadow_q.min0 < 4'd10);
      end
      2'd1: begin
        cur_val = {1'b0, shadow_q.min1};
        cur_ok  = (shadow_q.min1 < 3'd6);
      end
      2'd2: begin
        cur_val = shadow_q.hour0;
        cur_ok  = (shadow_q.hour0 < 4'd10);
      end
      2'd3: begin
        cur_val = {2'b00, shadow_q.hour1};
        cur_ok  = (shadow_q.hour1 != 2'd3);
      end
    endcase
  end

  // Blank the whole display on the slot-change cycle to avoid ghosting
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (!tick) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = cur_ok ? bcd_to_seg(cur_val) : SEG_DASH;
      dp_d  = (idx_q == 2'd2) ? ~colon_lit : 1'b1;
    end
  end

`ifdef COLON_BLINK_EN
  localparam int               BLK_W     = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_HALF - 1);

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             colon_on_q, colon_on_d;
  logic             blink_wrap;

  always_comb begin
    blink_wrap  = (blink_cnt_q == BLK_LAST);
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BLK_W'(1);
    colon_on_d  = blink_wrap ? ~colon_on_q : colon_on_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      colon_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      colon_on_q  <= colon_on_d;
    end
  end

  assign colon_lit = colon_on_q;
`else
  assign colon_lit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      idx_q     <= 2'd0;
      shadow_q  <= '0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan at SCAN_DIV=4: each vector is {an, seg, dp} sampled 1 time unit after a clock edge.
module tb_seg7_scan;

  logic       clk;
  logic       rst;
  logic [1:0] hour1;
  logic [3:0] hour0;
  logic [2:0] min1;
  logic [3:0] min0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [11:0] BLANK = 12'hFFF;

  seg7_scan #(
    .SCAN_DIV(4)
`ifdef COLON_BLINK_EN
    , .BLINK_HALF(16)
`endif
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .hour1(hour1),
    .hour0(hour0),
    .min1 (min1),
    .min0 (min0),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {an,seg,dp}=%b expected %b", tag, got, exp);
    end
  endtask

  // Checks slots first..last-1 of frame f (counted from reset release); segs = {hour1,hour0,min1,min0} patterns.
  task automatic run_slots(input int f, input int first, input int last, input logic [27:0] segs);
    logic [11:0] e;
    logic [3:0]  an_e;
    logic        dp2;
    int          idx;
    for (int i = first; i < last; i++) begin
      @(posedge clk);
      #1;
      idx  = i / 4;
      an_e = ~(4'b0001 << idx);
      dp2  = 1'b0;
`ifdef COLON_BLINK_EN
      dp2  = (f % 2 == 1);
`endif
      if (i % 4 == 3) e = BLANK;
      else e = {an_e, segs[idx*7 +: 7], (idx == 2) ? dp2 : 1'b1};
      chk($sformatf("frame%0d_slot%0d", f, i), {an, seg, dp}, e);
    end
  endtask

  initial begin
    rst   = 1'b1;
    hour1 = 2'd1;
    hour0 = 4'd2;
    min1  = 3'd3;
    min0  = 4'd4;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("reset%0d", i), {an, seg, dp}, BLANK);
    end
    rst = 1'b0;

    // First frame always shows 00:00
    run_slots(0, 0, 16, {S0, S0, S0, S0});
    // Live 12:34, min0 changes mid-frame but must not tear
    run_slots(1, 0, 6, {S1, S2, S3, S4});
    min0 = 4'd5;
    run_slots(1, 6, 16, {S1, S2, S3, S4});
    run_slots(2, 0, 6, {S1, S2, S3, S5});
    hour1 = 2'd3;
    hour0 = 4'd8;
    min1  = 3'd7;
    min0  = 4'hB;
    run_slots(2, 6, 16, {S1, S2, S3, S5});
    // Illegal digits become dashes; stop while an=1011 is showing
    run_slots(3, 0, 9, {SD, S8, SD, SD});

    rst   = 1'b1;
    hour1 = 2'd2;
    hour0 = 4'd3;
    min1  = 3'd5;
    min0  = 4'd9;
    @(posedge clk);
    #1;
    chk("midscan_reset", {an, seg, dp}, BLANK);
    rst = 1'b0;

    run_slots(0, 0, 16, {S0, S0, S0, S0});
    run_slots(1, 0, 16, {S2, S3, S5, S9});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
